// File: rtl/add_sub_issue.sv
//------------------------------------------------------------------------------
// Module   : add_sub_issue
// Brief    : Issue/capture stage wrapped around a 4-bit combinational
//            adder/subtractor. Accepts one request over a valid/ready
//            handshake, drives registered operands for one full cycle,
//            captures sum/carry with overflow and zero flags, and presents
//            the held result over a second valid/ready handshake. Counts
//            completed operations in a wrapping counter.
// Options  : ADD_SUB_ISSUE_SAT_EN - unsigned saturation of out_sum
//            (add overflow -> 4'hF, subtract borrow -> 4'h0).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module add_sub_issue #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_ctr,
  output logic [3:0]       op_a,
  output logic [3:0]       op_b,
  output logic             op_ctr,
  input  logic [3:0]       au_sum,
  input  logic             au_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sum_final;
  logic       ovf_calc;
  logic       zero_calc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; in_ready is masked while in reset
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Result shaping: overflow is judged on the latched operands and the raw
  // sum; zero is judged on the sum that will actually be presented
  always_comb begin
    if (op_ctr) begin
      ovf_calc = (op_a[3] != op_b[3]) && (au_sum[3] != op_a[3]);
    end else begin
      ovf_calc = (op_a[3] == op_b[3]) && (au_sum[3] != op_a[3]);
    end
`ifdef ADD_SUB_ISSUE_SAT_EN
    if (!op_ctr && au_carry) begin
      sum_final = 4'hF;
    end else if (op_ctr && !au_carry) begin
      sum_final = 4'h0;
    end else begin
      sum_final = au_sum;
    end
`else
    sum_final = au_sum;
`endif
    zero_calc = (sum_final == 4'h0);
  end

  // Operand latch, result capture and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= 4'h0;
      op_b      <= 4'h0;
      op_ctr    <= 1'b0;
      out_sum   <= 4'h0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      op_count  <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        op_a   <= in_a;
        op_b   <= in_b;
        op_ctr <= in_ctr;
      end
      if (state == S_EXEC) begin
        out_sum   <= sum_final;
        out_carry <= au_carry;
        out_ovf   <= ovf_calc;
        out_zero  <= zero_calc;
      end
      if (state == S_DONE && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_sub_issue.sv
//------------------------------------------------------------------------------
// Module   : tb_add_sub_issue
// Brief    : Directed self-checking bench for add_sub_issue. A behavioural
//            4-bit add/sub closes the operand -> sum/carry loop. A second
//            instance with CNT_W=2 shares the stimulus to exercise counter wrap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_add_sub_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_ctr;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic [3:0] op_a,      op_a2;
  logic [3:0] op_b,      op_b2;
  logic       op_ctr,    op_ctr2;
  logic [3:0] au_sum,    au_sum2;
  logic       au_carry,  au_carry2;
  logic       out_valid, out_valid2;
  logic [3:0] out_sum,   out_sum2;
  logic       out_carry, out_carry2;
  logic       out_ovf,   out_ovf2;
  logic       out_zero,  out_zero2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int checks   = 0;
  int failures = 0;
  int done_ops = 0;

  always #5 clk = ~clk;

  // Reference adder/subtractor: subtract is A + ~B + 1, carry = no borrow
  always_comb begin
    {au_carry, au_sum}   = op_ctr  ? ({1'b0, op_a}  + {1'b0, ~op_b}  + 5'd1)
                                   : ({1'b0, op_a}  + {1'b0, op_b});
    {au_carry2, au_sum2} = op_ctr2 ? ({1'b0, op_a2} + {1'b0, ~op_b2} + 5'd1)
                                   : ({1'b0, op_a2} + {1'b0, op_b2});
  end

  add_sub_issue #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctr(in_ctr),
    .op_a(op_a), .op_b(op_b), .op_ctr(op_ctr),
    .au_sum(au_sum), .au_carry(au_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .op_count(op_count)
  );

  add_sub_issue #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_ctr(in_ctr),
    .op_a(op_a2), .op_b(op_b2), .op_ctr(op_ctr2),
    .au_sum(au_sum2), .au_carry(au_carry2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_carry(out_carry2), .out_ovf(out_ovf2),
    .out_zero(out_zero2), .op_count(op_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready high: accept, EXEC, DONE, back to IDLE
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic ctr, input logic [3:0] e_sum, input logic e_carry,
                       input logic e_ovf, input logic e_zero);
    in_valid = 1'b1; in_a = a; in_b = b; in_ctr = ctr; out_ready = 1'b1;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_a = 4'hA; in_b = 4'h3; in_ctr = ~ctr;
    check({tag, ".op"}, {23'd0, op_a, op_b, op_ctr}, {23'd0, a, b, ctr});
    check({tag, ".busy"}, {30'd0, in_ready, out_valid}, 32'd0);
    tick();
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, {25'd0, out_sum, out_carry, out_ovf, out_zero},
          {25'd0, e_sum, e_carry, e_ovf, e_zero});
    tick();
    done_ops++;
    check({tag, ".count"}, {24'd0, op_count}, 32'(done_ops));
    check({tag, ".idle"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_ctr = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    check("rst.in_ready", {31'd0, in_ready}, 32'd0);
    check("rst.state", {22'd0, out_valid, op_a, op_b, op_ctr},  32'd0);
    check("rst.out", {20'd0, out_sum, out_carry, out_ovf, out_zero, op_count}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back transactions, accepts three cycles apart
    do_op("add4_2",  4'd4,  4'd2, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0);
    do_op("add7_5",  4'd7,  4'd5, 1'b0, 4'd12, 1'b0, 1'b1, 1'b0);
    do_op("sub9_1",  4'd9,  4'd1, 1'b1, 4'd8,  1'b1, 1'b0, 1'b0);
    do_op("sub12_8", 4'd12, 4'd8, 1'b1, 4'd4,  1'b1, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles, intervening request ignored
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd4; in_b = 4'd2; in_ctr = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; in_ctr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.hold", {19'd0, out_sum, op_a, op_b, op_ctr}, {19'd0, 4'd6, 4'd4, 4'd2, 1'b0});
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    done_ops++;
    check("bp.release", {22'd0, out_valid, in_ready, op_count}, {22'd0, 1'b0, 1'b1, 8'(done_ops)});
    check("bp.ignored", {23'd0, op_a, op_b, op_ctr}, {23'd0, 4'd4, 4'd2, 1'b0});

    // Zero and wrap-around / saturation boundaries
    do_op("sub5_5",  4'd5,  4'd5, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
`ifdef ADD_SUB_ISSUE_SAT_EN
    do_op("add12_8", 4'd12, 4'd8, 1'b0, 4'd15, 1'b1, 1'b1, 1'b0);
    do_op("sub2_5",  4'd2,  4'd5, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1);
`else
    do_op("add12_8", 4'd12, 4'd8, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0);
    do_op("sub2_5",  4'd2,  4'd5, 1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
`endif
    check("wrap2.pre", {30'd0, op_count2}, 32'(done_ops % 4));

    // Reset in DONE discards the operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd3; in_ctr = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("rd.in_done", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rd.cleared", {22'd0, out_valid, op_a, op_b, op_ctr}, 32'd0);
    check("rd.outs", {20'd0, out_sum, out_carry, out_ovf, out_zero, op_count}, 32'd0);
    check("rd.in_ready_low", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rd.in_ready_high", {31'd0, in_ready}, 32'd1);
    done_ops = 0;

    // Five completions on the CNT_W=2 instance wraps to 1
    do_op("w1", 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    do_op("w2", 4'd3, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    do_op("w3", 4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    do_op("w4", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    do_op("w5", 4'd6, 4'd3, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
    check("wrap2.count", {30'd0, op_count2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/add_sub_issue.md
# add_sub_issue

Sequencing stage that sits directly upstream of the 4-bit `add_sub` adder/subtractor and also captures what it returns.
- Accepts operation requests over a valid/ready handshake.
- Drives registered, stable operands (`a`, `b`, `ctr`) into `add_sub`.
- Samples `add_sub`'s `sum`/`carry` one cycle later and presents a held result with status flags over a second valid/ready handshake.
- Counts completed operations.

## Interface
Parameters:
- `CNT_W`, 8, width of completed-operation counter

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted this cycle when `in_valid && in_ready`
- `in_a`  in  4  operand A
- `in_b`  in  4  operand B
- `in_ctr`  in  1  0 = add, 1 = subtract (A−B)
- `op_a`  out  4  to `add_sub.a`
- `op_b`  out  4  to `add_sub.b`
- `op_ctr`  out  1  to `add_sub.ctr`
- `au_sum`  in  4  from `add_sub.sum`
- `au_carry`  in  1  from `add_sub.carry` (on subtract: 1 = no borrow)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_sum`  out  4  result
- `out_carry`  out  1  captured carry
- `out_ovf`  out  1  signed two's-complement overflow
- `out_zero`  out  1  `out_sum == 0`
- `op_count`  out  `CNT_W`  completed operations, wraps

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, latch `in_a`/`in_b`/`in_ctr` into `op_a`/`op_b`/`op_ctr` and go to EXEC.
  - EXEC: operands stable for one full cycle. At the end of the cycle, register `au_sum`/`au_carry` and computed flags into `out_*`, then go to DONE.
  - DONE: `out_valid=1`. `out_*` and `op_*` are held. On `out_ready`, increment `op_count` and go to IDLE.
- `in_ready` is 0 in EXEC and DONE; requests are never buffered.
- `out_valid` is 0 outside DONE; `out_*` keep their last value after the handshake.
- Overflow flag:
  - add: `out_ovf = (a[3]==b[3]) && (au_sum[3]!=a[3])`.
  - sub: `out_ovf = (a[3]!=b[3]) && (au_sum[3]!=a[3])`.
  - Both use the latched operands.
- `out_zero` is computed on the final `out_sum`, after saturation when it is enabled.
- `op_count` wraps from 2^CNT_W−1 to 0.
- Reset:
  - State IDLE.
  - `op_a`, `op_b`, `op_ctr`, `out_sum`, `out_carry`, `out_ovf`, `out_zero`, `op_count` are all 0. `out_valid` is 0.
  - `in_ready` is forced to 0 while `rst` is high.
- Reset asserted in EXEC or DONE discards the in-flight operation; no count increment.
- `in_valid` held while not ready: no effect. `in_a`/`in_b`/`in_ctr` may change freely outside IDLE.

## Timing
- Request accepted at edge N: `op_*` are valid after N, results are sampled at N+1, and `out_valid` is high after N+1.
- Latency is 2 cycles from accept to `out_valid`.
- With `out_ready` held high: DONE lasts 1 cycle, the next accept is at edge N+3, and throughput is 1 operation per 3 cycles.
- `op_count` updates at the edge where `out_valid && out_ready`.
- `au_sum`/`au_carry` must settle within one cycle: the `add_sub` path is combinational.

## Configuration
- `ADD_SUB_ISSUE_SAT_EN` defined: unsigned saturation of `out_sum`.
  - add with `au_carry=1` gives `4'hF`.
  - sub with `au_carry=0` (borrow) gives `4'h0`.
  - `out_carry` and `out_ovf` still reflect the raw `add_sub` outputs.
- Undefined: `out_sum = au_sum` unmodified (wrap-around).

## Test plan
- Add 4+2 with `out_ready=1`:
  - `op_*` = (4, 2, 0) one cycle after accept.
  - `out_sum=6`, `carry=0`, `ovf=0`, `zero=0`, `out_valid` 2 cycles after accept.
  - `op_count=1`.
- Add 7+5 → `sum=12`, `carry=0`, `ovf=1`. Sub 9−1 → `sum=8`, `carry=1`, `ovf=0`. Sub 12−8 → `sum=4`, `carry=1`, `ovf=0`. Back-to-back accepts 3 cycles apart.
- Backpressure: hold `out_ready=0` for 5 cycles after sum 6.
  - `out_valid`, `out_sum`, and `op_*` stay stable.
  - `in_ready=0` throughout, and a request presented meanwhile is ignored.
- Zero/wrap:
  - sub 5−5 → `sum=0`, `zero=1`, `carry=1`.
  - Add 12+8: without macro `sum=4`, `carry=1`; with `ADD_SUB_ISSUE_SAT_EN` `sum=15`.
  - Sub 2−5: without macro `sum=13`, `carry=0`; with macro `sum=0`, `zero=1`.
- Reset during DONE: assert `rst` for 1 cycle.
  - Next cycle: `out_valid=0`, all outputs 0, `op_count` unchanged-at-reset (0), `in_ready=1` after `rst` deasserts.
- Counter wrap (`CNT_W=2`): 5 completed operations → `op_count=1`.
